// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, constants and frame-classification helpers for
//               the 4x4 matrix keypad scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    // Key FSM states
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } kp_state_t;

    localparam logic [3:0] COL_IDLE  = 4'b1111;  // no column driven
    localparam logic [3:0] COL_FIRST = 4'b1110;  // column 0 driven
    localparam int         KEY_W     = 4;
    localparam int         FRAME_W   = 16;

    // Number of set bits in a frame, saturated at 2 (0, 1, or "many").
    function automatic logic [1:0] frame_count_sat(input logic [FRAME_W-1:0] f);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            n = n + 5'(f[i]);
        end
        return (n >= 5'd2) ? 2'd2 : n[1:0];
    endfunction

    // Index of a set bit; meaningful only when exactly one bit is set.
    function automatic logic [KEY_W-1:0] frame_index(input logic [FRAME_W-1:0] f);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < FRAME_W; i++) begin
            if (f[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : keypad_tick_gen
// Description : Terminal-count tick generator. Counts 0..TERMINAL while en is
//               high and asserts tick during the terminal count. Dropping en
//               returns the counter to zero.
// Ports       : clk, rst (sync, active-high), en, tick
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_tick_gen #(
    parameter int                   CNT_WIDTH = 16,
    parameter logic [CNT_WIDTH-1:0] TERMINAL  = '1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 w_at_term;

    assign w_at_term = (r_cnt == TERMINAL);
    assign tick      = en && w_at_term;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_cnt <= '0;
        end else if (w_at_term) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scan_unit.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_unit
// Description : 4x4 matrix keypad scanner. Drives one column low at a time,
//               samples active-low rows, assembles 16-bit frames and debounces
//               whole frames to report a single pressed key.
// Ports       : clk, rst (sync, active-high), en, row_in[3:0] (active-low,
//               async), col_out[3:0] (one-cold), key_code[3:0] ({col,row}),
//               key_valid (1-cycle pulse), key_held
// Options     : KEYPAD_REPEAT_EN - auto-repeat key_valid every REPEAT_FRAMES
//               frames while the accepted key stays the only key pressed.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_unit
    import keypad_pkg::*;
#(
    parameter int                   CNT_WIDTH       = 16,
    parameter logic [CNT_WIDTH-1:0] TICKS_PER_COL   = 16'd25000,
    parameter int                   DEBOUNCE_FRAMES = 4,
    parameter int                   REPEAT_FRAMES   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [CNT_WIDTH-1:0] c_TERM = TICKS_PER_COL - CNT_WIDTH'(1);
    localparam logic [3:0]           c_DB   = 4'(DEBOUNCE_FRAMES);

    // Elaboration-time parameter range guards
    if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
        $error("DEBOUNCE_FRAMES out of range 1..15");
    end
    if (REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_bad_repeat
        $error("REPEAT_FRAMES out of range 1..255");
    end
    if (TICKS_PER_COL < 4) begin : g_bad_ticks
        $error("TICKS_PER_COL must be at least 4");
    end

    // ---------------------------------------------------------------- sync
    logic [3:0] r_row_meta;
    logic [3:0] r_row_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
        end
    end

    // ---------------------------------------------------------------- scan
    logic [3:0]         r_col_out;
    logic [1:0]         r_col_idx;
    logic [FRAME_W-1:0] r_work;
    logic [FRAME_W-1:0] w_work_next;
    logic               w_scan_run;
    logic               w_tick;
    logic               w_frame_done;

    // The dwell counter only runs once a column is actually driven, so the
    // first column gets a full dwell just like the others.
    assign w_scan_run   = en && (r_col_out != COL_IDLE);
    assign w_frame_done = w_tick && (r_col_idx == 2'd3);

    keypad_tick_gen #(
        .CNT_WIDTH (CNT_WIDTH),
        .TERMINAL  (c_TERM)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .en   (w_scan_run),
        .tick (w_tick)
    );

    always_comb begin
        w_work_next = r_work;
        case (r_col_idx)
            2'd0:    w_work_next[3:0]   = ~r_row_sync;
            2'd1:    w_work_next[7:4]   = ~r_row_sync;
            2'd2:    w_work_next[11:8]  = ~r_row_sync;
            default: w_work_next[15:12] = ~r_row_sync;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_col_out <= COL_IDLE;
            r_col_idx <= 2'd0;
            r_work    <= '0;
        end else if (r_col_out == COL_IDLE) begin
            r_col_out <= COL_FIRST;
            r_col_idx <= 2'd0;
            r_work    <= '0;
        end else if (w_tick) begin
            r_col_out <= {r_col_out[2:0], r_col_out[3]};
            r_col_idx <= r_col_idx + 2'd1;
            r_work    <= w_frame_done ? '0 : w_work_next;
        end
    end

    assign col_out = r_col_out;

    // ---------------------------------------------------------------- FSM
    kp_state_t        r_state, w_state_next;
    logic [3:0]       r_dcnt, w_dcnt_next;
    logic [KEY_W-1:0] r_cand, w_cand_next;
    logic [KEY_W-1:0] r_key_code, w_code_next;
    logic             r_key_valid, w_valid_next;
    logic             r_key_held, w_held_next;
    logic             w_accept;
    logic [1:0]       w_cnt;
    logic [KEY_W-1:0] w_idx;
    logic             w_zero;
    logic             w_one;

    assign w_cnt  = frame_count_sat(w_work_next);
    assign w_idx  = frame_index(w_work_next);
    assign w_zero = (w_cnt == 2'd0);
    assign w_one  = (w_cnt == 2'd1);

`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] c_REP = 8'(REPEAT_FRAMES);
    logic [7:0] r_rep_cnt, w_rep_next;
`endif

    always_comb begin
        w_state_next = r_state;
        w_dcnt_next  = r_dcnt;
        w_cand_next  = r_cand;
        w_code_next  = r_key_code;
        w_valid_next = 1'b0;
        w_held_next  = r_key_held;
        w_accept     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        w_rep_next   = r_rep_cnt;
`endif
        if (!en) begin
            w_state_next = IDLE;
            w_dcnt_next  = 4'd0;
            w_cand_next  = '0;
            w_held_next  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
            w_rep_next   = 8'd0;
`endif
        end else if (w_frame_done) begin
            case (r_state)
                IDLE: begin
                    if (w_one) begin
                        w_cand_next = w_idx;
                        w_dcnt_next = 4'd1;
                        if (c_DB == 4'd1) begin
                            w_accept = 1'b1;
                        end else begin
                            w_state_next = PRESS_DB;
                        end
                    end
                end
                PRESS_DB: begin
                    if (w_one && (w_idx == r_cand)) begin
                        w_dcnt_next = r_dcnt + 4'd1;
                        if (w_dcnt_next == c_DB) begin
                            w_accept = 1'b1;
                        end
                    end else begin
                        w_state_next = IDLE;
                        w_dcnt_next  = 4'd0;
                    end
                end
                HELD: begin
                    if (w_zero) begin
                        w_dcnt_next = 4'd1;
`ifdef KEYPAD_REPEAT_EN
                        w_rep_next  = 8'd0;
`endif
                        if (c_DB == 4'd1) begin
                            w_held_next  = 1'b0;
                            w_state_next = IDLE;
                            w_dcnt_next  = 4'd0;
                        end else begin
                            w_state_next = RELEASE_DB;
                        end
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (w_one && (w_idx == r_key_code)) begin
                            if (r_rep_cnt + 8'd1 == c_REP) begin
                                w_valid_next = 1'b1;
                                w_rep_next   = 8'd0;
                            end else begin
                                w_rep_next   = r_rep_cnt + 8'd1;
                            end
                        end else begin
                            w_rep_next = 8'd0;
                        end
`endif
                    end
                end
                RELEASE_DB: begin
                    if (w_zero) begin
                        w_dcnt_next = r_dcnt + 4'd1;
                        if (w_dcnt_next == c_DB) begin
                            w_held_next  = 1'b0;
                            w_state_next = IDLE;
                            w_dcnt_next  = 4'd0;
                        end
                    end else begin
                        // Release bounced: key is still down.
                        w_state_next = HELD;
                        w_dcnt_next  = 4'd0;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_dcnt_next  = 4'd0;
                end
            endcase

            if (w_accept) begin
                w_code_next  = w_cand_next;
                w_valid_next = 1'b1;
                w_held_next  = 1'b1;
                w_state_next = HELD;
                w_dcnt_next  = 4'd0;
`ifdef KEYPAD_REPEAT_EN
                w_rep_next   = 8'd0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dcnt      <= 4'd0;
            r_cand      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= 8'd0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_dcnt      <= w_dcnt_next;
            r_cand      <= w_cand_next;
            r_key_code  <= w_code_next;
            r_key_valid <= w_valid_next;
            r_key_held  <= w_held_next;
`ifdef KEYPAD_REPEAT_EN
            r_rep_cnt   <= w_rep_next;
`endif
        end
    end

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_unit
// Description : Directed self-checking bench for keypad_scan_unit with a
//               behavioural 4x4 key matrix driving row_in from col_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int checks = 0;
    int errors = 0;
    int vcount = 0;

    always #5 clk = ~clk;

    keypad_scan_unit #(
        .CNT_WIDTH       (16),
        .TICKS_PER_COL   (16'd4),
        .DEBOUNCE_FRAMES (4),
        .REPEAT_FRAMES   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Key matrix: a pressed key shorts its row to its column.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col_out[c] && pressed[c*4+r]) row_in[r] = 1'b0;
            end
        end
    end

    // Counts high cycles of key_valid, so a stretched pulse is visible too.
    always @(posedge clk) begin
        if (!rst && key_valid) vcount <= vcount + 1;
    end

    // Returns one cycle after a frame boundary (col_out back to 1110).
    task automatic wait_frame();
        int n;
        n = 0;
        while (col_out !== 4'b0111 && n < 200) begin @(negedge clk); n++; end
        while (col_out !== 4'b1110 && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL frame_timeout col_out=%b required a frame boundary", col_out);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; pressed = '0;
        repeat (3) @(negedge clk);
        checks++; if (col_out !== 4'b1111) begin errors++; $display("FAIL rst_col got %b exp 1111", col_out); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL rst_code got %h exp 0", key_code); end
        checks++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin errors++;
            $display("FAIL rst_flags got v=%b h=%b exp 0 0", key_valid, key_held); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (col_out !== 4'b1111) begin errors++; $display("FAIL idle_col got %b exp 1111", col_out); end
    endtask

    task automatic test_scan();
        int base;
        base = vcount;
        en = 1'b1;
        @(negedge clk);
        checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL first_col got %b exp 1110", col_out); end
        repeat (3) @(negedge clk);
        checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL dwell_col0 got %b exp 1110", col_out); end
        @(negedge clk);
        checks++; if (col_out !== 4'b1101) begin errors++; $display("FAIL col1 got %b exp 1101", col_out); end
        repeat (4) @(negedge clk);
        checks++; if (col_out !== 4'b1011) begin errors++; $display("FAIL col2 got %b exp 1011", col_out); end
        repeat (4) @(negedge clk);
        checks++; if (col_out !== 4'b0111) begin errors++; $display("FAIL col3 got %b exp 0111", col_out); end
        repeat (4) @(negedge clk);
        checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL wrap got %b exp 1110", col_out); end
        wait_frame(); wait_frame();
        checks++; if (vcount != base || key_held !== 1'b0) begin errors++;
            $display("FAIL idle_rows pulses=%0d held=%b exp 0 0", vcount - base, key_held); end
    endtask

    task automatic test_single_press();
        int base;
        base = vcount;
        pressed = 16'h0200;  // col2,row1 -> 4'h9
        for (int f = 1; f <= 6; f++) begin
            wait_frame();
            checks++; if (vcount - base != ((f >= 4) ? 1 : 0)) begin errors++;
                $display("FAIL press9_f%0d pulses=%0d exp %0d", f, vcount - base, (f >= 4) ? 1 : 0); end
        end
        checks++; if (key_code !== 4'h9 || key_held !== 1'b1) begin errors++;
            $display("FAIL press9_code got %h held=%b exp 9 1", key_code, key_held); end
        pressed = '0;
        repeat (4) wait_frame();
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release9 held=%b exp 0", key_held); end
    endtask

    task automatic test_bounce();
        int base;
        base = vcount;
        for (int f = 1; f <= 8; f++) begin
            pressed = (f % 2 == 1) ? 16'h0200 : 16'h0000;
            wait_frame();
        end
        checks++; if (vcount != base || key_held !== 1'b0) begin errors++;
            $display("FAIL bounce pulses=%0d held=%b exp 0 0", vcount - base, key_held); end
        // A clean press must need a full debounce from IDLE.
        pressed = 16'h0200;
        repeat (3) wait_frame();
        checks++; if (vcount != base) begin errors++; $display("FAIL bounce_idle_f3 pulses=%0d exp 0", vcount - base); end
        wait_frame();
        checks++; if (vcount != base + 1) begin errors++; $display("FAIL bounce_idle_f4 pulses=%0d exp 1", vcount - base); end
        pressed = '0;
        repeat (4) wait_frame();
    endtask

    task automatic test_multi_release();
        int base;
        base = vcount;
        pressed = 16'h8001;  // keys 0 and F together
        repeat (6) wait_frame();
        checks++; if (vcount != base || key_held !== 1'b0) begin errors++;
            $display("FAIL multi pulses=%0d held=%b exp 0 0", vcount - base, key_held); end
        pressed = 16'h0020;  // key 5
        repeat (4) wait_frame();
        checks++; if (vcount != base + 1 || key_code !== 4'h5 || key_held !== 1'b1) begin errors++;
            $display("FAIL press5 pulses=%0d code=%h held=%b exp 1 5 1", vcount - base, key_code, key_held); end
        pressed = '0;
        repeat (2) wait_frame();
        pressed = 16'h0020;  // bounce at release frame 3 -> back to HELD
        wait_frame();
        pressed = '0;
        repeat (3) wait_frame();
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL rel_bounce_3 held=%b exp 1", key_held); end
        wait_frame();
        checks++; if (key_held !== 1'b0 || vcount != base + 1) begin errors++;
            $display("FAIL rel_bounce_4 held=%b pulses=%0d exp 0 1", key_held, vcount - base); end
    endtask

    task automatic test_enable_drop();
        int base;
        base = vcount;
        pressed = 16'h0040;  // col1,row2 -> 4'h6
        repeat (2) wait_frame();
        en = 1'b0;
        @(negedge clk);
        checks++; if (col_out !== 4'b1111) begin errors++; $display("FAIL en_drop_col got %b exp 1111", col_out); end
        repeat (5) @(negedge clk);
        checks++; if (vcount != base || key_held !== 1'b0) begin errors++;
            $display("FAIL en_drop pulses=%0d held=%b exp 0 0", vcount - base, key_held); end
        en = 1'b1;
        @(negedge clk);
        checks++; if (col_out !== 4'b1110) begin errors++; $display("FAIL en_restart_col got %b exp 1110", col_out); end
        repeat (3) wait_frame();
        checks++; if (vcount != base) begin errors++; $display("FAIL en_re_f3 pulses=%0d exp 0", vcount - base); end
        wait_frame();
        checks++; if (vcount != base + 1 || key_code !== 4'h6) begin errors++;
            $display("FAIL en_re_f4 pulses=%0d code=%h exp 1 6", vcount - base, key_code); end
        pressed = '0;
        repeat (4) wait_frame();
    endtask

    task automatic test_repeat();
        int base;
        int exp;
        base = vcount;
        pressed = 16'h0400;  // col2,row2 -> 4'hA
        for (int f = 1; f <= 24; f++) begin
            wait_frame();
`ifdef KEYPAD_REPEAT_EN
            exp = ((f >= 4) ? 1 : 0) + ((f >= 12) ? 1 : 0) + ((f >= 20) ? 1 : 0);
`else
            exp = (f >= 4) ? 1 : 0;
`endif
            checks++; if (vcount - base != exp) begin errors++;
                $display("FAIL hold_A_f%0d pulses=%0d exp %0d", f, vcount - base, exp); end
        end
        checks++; if (key_code !== 4'hA) begin errors++; $display("FAIL hold_A_code got %h exp A", key_code); end
        exp = vcount - base;
        pressed = '0;
        repeat (12) wait_frame();
        checks++; if (vcount - base != exp || key_held !== 1'b0) begin errors++;
            $display("FAIL after_release pulses=%0d held=%b exp %0d 0", vcount - base, key_held, exp); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_single_press();
        test_bounce();
        test_multi_release();
        test_enable_drop();
        test_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
